ram_param_init: RTL and testbench



---
 rtl/ram_param_init.sv | 117 +++++++++++
 tb/tb_ram_param_init.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_param_init.sv
// Single-port RAM that zeroes itself after reset.
// After reset the block walks an internal counter across every address and
// writes zero there, one word per cycle. Only then does it raise ready and
// accept user traffic. Read latency is one cycle, or two when OUT_REG=1.
// Same-address read/write behaviour is chosen with RD_MODE.
module ram_param_init #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int RD_MODE = 0,   // 0: read-first, 1: write-first
  parameter int OUT_REG = 0    // 1: extra output register stage
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              ready
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  // vld_pipe[0] is the read accepted this cycle; vld_pipe[STAGES] lines up with dout
  logic [STAGES:0]   vld_pipe;
  logic [STAGES:1]   vld_q;

  // User traffic is only honoured once the clear sweep has finished
  assign rd_acc = (state_q == READY) && re;
  assign wr_acc = (state_q == READY) && we;

  // Next state: sweep the counter through every address, then settle in READY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;              // wraps to 0 after the last address
      if (cnt_q == '1) state_d = READY;
    end
  end

  // State, clear counter and registered ready flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == READY);
    end
  end

  assign ready = ready_q;

  // Storage: the clear sweep owns the write port until READY; no reset on the array
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem[cnt_q] <= '0;
    else if (wr_acc)      mem[addr]  <= din;
  end

  // Read data source: old contents, or din on a write-first collision
  always_comb begin
    rd_d = mem[addr];
    if ((RD_MODE != 0) && we) rd_d = din;
  end

  // First read stage: capture only on an accepted read so dout holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rd_q <= '0;
    else if (rd_acc) rd_q <= rd_d;
  end

  assign vld_pipe = {vld_q, rd_acc};

  // Valid shift register tracking each accepted read down the pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      for (int s = 1; s <= STAGES; s++) vld_q[s] <= vld_pipe[s-1];
    end
  end

  assign dout_valid = vld_pipe[STAGES];

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] out_q;

    // Optional output stage advances only when the first stage held a fresh read
    always_ff @(posedge clk or posedge reset) begin
      if (reset)         out_q <= '0;
      else if (vld_q[1]) out_q <= rd_q;
    end

    assign dout = out_q;
  end else begin : g_noreg
    assign dout = rd_q;
  end

endmodule

// File: tb/tb_ram_param_init.sv
// Bench for ram_param_init: a default instance (16x256, read-first, no
// output register) and a small instance (32x16, write-first, output
// register). Both share clock and reset and are checked against array models.
module tb_ram_param_init;

  logic clk;
  logic rst;

  logic        we0, re0, dv0, rdy0;
  logic [7:0]  addr0;
  logic [15:0] din0, dout0;

  logic        we1, re1, dv1, rdy1;
  logic [3:0]  addr1;
  logic [31:0] din1, dout1;

  int errors = 0;
  int checks = 0;

  logic [15:0] m0 [256];
  logic [31:0] m1 [16];

  ram_param_init u_big (
    .clk(clk), .reset(rst), .we(we0), .re(re0), .addr(addr0), .din(din0),
    .dout(dout0), .dout_valid(dv0), .ready(rdy0)
  );

  ram_param_init #(.DATA_W(32), .ADDR_W(4), .RD_MODE(1), .OUT_REG(1)) u_small (
    .clk(clk), .reset(rst), .we(we1), .re(re1), .addr(addr1), .din(din1),
    .dout(dout1), .dout_valid(dv1), .ready(rdy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    we0 = 1'b0; re0 = 1'b0; we1 = 1'b0; re1 = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m0[i] = '0;
    for (int i = 0; i < 16; i++)  m1[i] = '0;
  endtask

  task automatic test_reset();
    idle();
    addr0 = '0; din0 = '0; addr1 = '0; din1 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dout0 !== 16'h0) begin errors++; $display("FAIL rst_dout0: got %h want 0000", dout0); end
    checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL rst_dv0: got %b want 0", dv0); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL rst_rdy0: got %b want 0", rdy0); end
    checks++; if (dout1 !== 32'h0) begin errors++; $display("FAIL rst_dout1: got %h want 0", dout1); end
    checks++; if (dv1 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL rst_small: got dv=%b rdy=%b want 0 0", dv1, rdy1); end
  endtask

  // Release reset with a write+read to 0x20 held asserted; both must be ignored
  task automatic test_clear();
    int c0 = 0, c1 = 0;
    bit bad = 0;
    @(negedge clk);
    rst = 1'b0;
    we0 = 1'b1; re0 = 1'b1; addr0 = 8'h20; din0 = 16'hAAAA;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (dv0) bad = 1;
      if (rdy1 && c1 == 0) c1 = n;
      if (rdy0) begin c0 = n; break; end
    end
    idle();
    model_clear();
    checks++; if (c0 != 256) begin errors++; $display("FAIL clear_len_big: got %0d want 256", c0); end
    checks++; if (c1 != 16) begin errors++; $display("FAIL clear_len_small: got %0d want 16", c1); end
    checks++; if (bad) begin errors++; $display("FAIL clear_no_valid: got dout_valid=1 want 0"); end
  endtask

  task automatic test_read_zero();
    logic [7:0] al [4];
    al[0] = 8'h00; al[1] = 8'h7F; al[2] = 8'hFF; al[3] = 8'h20;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      re0 = 1'b1; addr0 = al[i];
      @(negedge clk);
      re0 = 1'b0;
      checks++; if (dv0 !== 1'b1 || dout0 !== 16'h0000) begin errors++; $display("FAIL read_zero[%h]: got dv=%b d=%h want 1 0000", al[i], dv0, dout0); end
      @(negedge clk);
      checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL read_zero_gap[%h]: got %b want 0", al[i], dv0); end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] a8;
    we0 = 1'b1; addr0 = 8'h12; din0 = 16'hBEEF; m0[8'h12] = 16'hBEEF;
    we1 = 1'b1; addr1 = 4'hF; din1 = 32'hDEADBEEF; m1[15] = 32'hDEADBEEF;
    @(negedge clk);
    idle();
    re0 = 1'b1; addr0 = 8'h12;
    a8 = 8'h1F; re1 = 1'b1; addr1 = a8[3:0];
    @(negedge clk);
    idle();
    checks++; if (dv0 !== 1'b1 || dout0 !== 16'hBEEF) begin errors++; $display("FAIL wr_rd_big: got dv=%b d=%h want 1 beef", dv0, dout0); end
    checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL wr_rd_small_early: got %b want 0", dv1); end
    @(negedge clk);
    checks++; if (dv0 !== 1'b0 || dout0 !== 16'hBEEF) begin errors++; $display("FAIL hold_big: got dv=%b d=%h want 0 beef", dv0, dout0); end
    checks++; if (dv1 !== 1'b1 || dout1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_small: got dv=%b d=%h want 1 deadbeef", dv1, dout1); end
    @(negedge clk);
    checks++; if (dv1 !== 1'b0 || dout1 !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_small: got dv=%b d=%h want 0 deadbeef", dv1, dout1); end
  endtask

  task automatic test_collision();
    we0 = 1'b1; addr0 = 8'h05; din0 = 16'h1111;
    we1 = 1'b1; addr1 = 4'h5; din1 = 32'h1111;
    @(negedge clk);
    re0 = 1'b1; din0 = 16'h2222;
    re1 = 1'b1; din1 = 32'h2222;
    @(negedge clk);
    m0[5] = 16'h2222; m1[5] = 32'h2222;
    we0 = 1'b0; we1 = 1'b0;
    checks++; if (dv0 !== 1'b1 || dout0 !== 16'h1111) begin errors++; $display("FAIL coll_big: got dv=%b d=%h want 1 1111", dv0, dout0); end
    @(negedge clk);
    idle();
    checks++; if (dv0 !== 1'b1 || dout0 !== 16'h2222) begin errors++; $display("FAIL coll_big_after: got dv=%b d=%h want 1 2222", dv0, dout0); end
    checks++; if (dv1 !== 1'b1 || dout1 !== 32'h2222) begin errors++; $display("FAIL coll_small: got dv=%b d=%h want 1 2222", dv1, dout1); end
    @(negedge clk);
    checks++; if (dv1 !== 1'b1 || dout1 !== 32'h2222) begin errors++; $display("FAIL coll_small_after: got dv=%b d=%h want 1 2222", dv1, dout1); end
    checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL coll_big_end: got %b want 0", dv0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      we0 = 1'b1; addr0 = 8'h30 + 8'(i); din0 = 16'($urandom);
      m0[addr0] = din0;
      @(negedge clk);
    end
    we0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      re0 = 1'b1; addr0 = 8'h30 + 8'(i);
      @(negedge clk);
      checks++; if (dv0 !== 1'b1 || dout0 !== m0[8'h30 + 8'(i)]) begin errors++; $display("FAIL b2b[%0d]: got dv=%b d=%h want 1 %h", i, dv0, dout0, m0[8'h30 + 8'(i)]); end
    end
    re0 = 1'b0;
    @(negedge clk);
    checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", dv0); end
  endtask

  // Read-first, latency 1: a read returns the contents before the same-cycle write
  task automatic test_random_big();
    logic        rv [0:255];
    logic [15:0] rd [0:255];
    logic [15:0] last = '0;
    for (int t = 0; t <= 200; t++) begin
      if (t < 200) begin
        we0 = 1'($urandom_range(0, 1));
        re0 = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        addr0 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        din0 = 16'($urandom);
      end else idle();
      rv[t] = re0;
      rd[t] = m0[addr0];
      if (we0) m0[addr0] = din0;
      @(negedge clk);
      if (rv[t]) last = rd[t];
      checks++; if (dv0 !== rv[t]) begin errors++; $display("FAIL rnd_big_vld t=%0d: got %b want %b", t, dv0, rv[t]); end
      checks++; if (dout0 !== last) begin errors++; $display("FAIL rnd_big_dout t=%0d: got %h want %h", t, dout0, last); end
    end
  endtask

  // Write-first, latency 2
  task automatic test_random_small();
    logic        rv [0:255];
    logic [31:0] rd [0:255];
    logic [31:0] last = '0;
    bit seen = 0;
    for (int t = 0; t <= 121; t++) begin
      if (t < 120) begin
        we1 = 1'($urandom_range(0, 1));
        re1 = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        addr1 = 4'($urandom_range(0, 15));
        din1 = $urandom;
      end else idle();
      rv[t] = re1;
      rd[t] = we1 ? din1 : m1[addr1];
      if (we1) m1[addr1] = din1;
      @(negedge clk);
      if (t >= 1) begin
        if (rv[t-1]) begin last = rd[t-1]; seen = 1; end
        checks++; if (dv1 !== rv[t-1]) begin errors++; $display("FAIL rnd_small_vld t=%0d: got %b want %b", t, dv1, rv[t-1]); end
        if (seen) begin
          checks++; if (dout1 !== last) begin errors++; $display("FAIL rnd_small_dout t=%0d: got %h want %h", t, dout1, last); end
        end
      end
    end
  endtask

  task automatic test_reset_midread();
    int c0 = 0, c1 = 0;
    bit bad = 0;
    we0 = 1'b1; addr0 = 8'h40; din0 = 16'h3C3C;
    @(negedge clk);
    we0 = 1'b0; re0 = 1'b1; addr0 = 8'h40;
    re1 = 1'b1; addr1 = 4'hF;
    @(posedge clk); #1;            // small instance now has the read in flight
    rst = 1'b1;
    #1;
    checks++; if (dout0 !== 16'h0 || dv0 !== 1'b0 || rdy0 !== 1'b0) begin errors++; $display("FAIL mid_rst_big: got d=%h dv=%b rdy=%b want 0000 0 0", dout0, dv0, rdy0); end
    checks++; if (dout1 !== 32'h0 || dv1 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL mid_rst_small: got d=%h dv=%b rdy=%b want 0 0 0", dout1, dv1, rdy1); end
    idle();
    @(negedge clk);
    checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL mid_rst_drop: got %b want 0", dv1); end
    rst = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (dv0 || dv1) bad = 1;
      if (rdy1 && c1 == 0) c1 = n;
      if (rdy0) begin c0 = n; break; end
    end
    model_clear();
    checks++; if (c0 != 256) begin errors++; $display("FAIL reclear_big: got %0d want 256", c0); end
    checks++; if (c1 != 16) begin errors++; $display("FAIL reclear_small: got %0d want 16", c1); end
    checks++; if (bad) begin errors++; $display("FAIL reclear_vld: got dout_valid=1 want 0"); end
    @(negedge clk);
    re0 = 1'b1; addr0 = 8'h40;
    re1 = 1'b1; addr1 = 4'hF;
    @(negedge clk);
    idle();
    checks++; if (dv0 !== 1'b1 || dout0 !== m0[8'h40]) begin errors++; $display("FAIL reclear_rd_big: got dv=%b d=%h want 1 %h", dv0, dout0, m0[8'h40]); end
    @(negedge clk);
    checks++; if (dv1 !== 1'b1 || dout1 !== m1[15]) begin errors++; $display("FAIL reclear_rd_small: got dv=%b d=%h want 1 %h", dv1, dout1, m1[15]); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_read_zero();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_random_big();
    test_random_small();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
